// File: rtl/up_down_wrap_display.sv
// up_down_wrap_display
// Watches a 3-bit up/down count. It classifies each change as a step, a hold
// or an illegal jump, and keeps a two-digit BCD revolution count.
// It scans a 4-digit seven-segment display. From the rightmost digit the digits
// show: live count, error marker, revolutions ones, revolutions tens.
module up_down_wrap_display #(
  parameter int   SCAN_DIV    = 16,
  parameter logic SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] q,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       wrap_up,
  output logic       wrap_dn,
  output logic       err
);

  // Active-high {g,f,e,d,c,b,a} pattern for a decimal digit; others blank.
  function automatic logic [6:0] seg_hex7(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  localparam logic [6:0] SEG_E_HI    = 7'b1111001;
  localparam logic [6:0] SEG_RST_VAL = SEG_ACT_LOW ? 7'b1000000 : 7'b0111111;

  logic [2:0]  q_s_r, q_p_r;
  logic        vld_1_r, p_vld_r;
  logic [3:0]  rev_ones_r, rev_tens_r;
  logic [15:0] scan_cnt_r;
  logic [1:0]  dig_r;

  logic [2:0] d_s;
  logic       wrap_up_s, wrap_dn_s, jump_s, err_s;
  logic [3:0] rev_ones_s, rev_tens_s;
  logic [6:0] seg_hi_s, seg_s;
  logic [3:0] an_s;

  // Capture the count and its predecessor. Trust the pair only once both
  // registers hold samples taken after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_s_r   <= 3'd0;
      q_p_r   <= 3'd0;
      vld_1_r <= 1'b0;
      p_vld_r <= 1'b0;
    end else begin
      q_s_r   <= q;
      q_p_r   <= q_s_r;
      vld_1_r <= 1'b1;
      p_vld_r <= vld_1_r;
    end
  end

  // Classify the latest change and compute the next revolution count and error flag.
  always_comb begin
    d_s        = q_s_r - q_p_r;
    wrap_up_s  = 1'b0;
    wrap_dn_s  = 1'b0;
    jump_s     = 1'b0;
    rev_ones_s = rev_ones_r;
    rev_tens_s = rev_tens_r;
    err_s      = err;
    if (p_vld_r) begin
      wrap_up_s = (q_p_r == 3'd7) && (q_s_r == 3'd0);
      wrap_dn_s = (q_p_r == 3'd0) && (q_s_r == 3'd7);
      jump_s    = (d_s >= 3'd2) && (d_s <= 3'd6);
    end else begin
      wrap_up_s = 1'b0;
    end
    if (clr) begin
      wrap_up_s  = 1'b0;
      wrap_dn_s  = 1'b0;
      rev_ones_s = 4'd0;
      rev_tens_s = 4'd0;
      err_s      = 1'b0;
    end else if (jump_s) begin
      err_s = 1'b1;
    end else if (wrap_up_s) begin
      if (rev_ones_r == 4'd9) begin
        rev_ones_s = 4'd0;
        rev_tens_s = (rev_tens_r == 4'd9) ? 4'd0 : rev_tens_r + 4'd1;
      end else begin
        rev_ones_s = rev_ones_r + 4'd1;
      end
    end else if (wrap_dn_s) begin
      if (rev_ones_r == 4'd0) begin
        rev_ones_s = 4'd9;
        rev_tens_s = (rev_tens_r == 4'd0) ? 4'd9 : rev_tens_r - 4'd1;
      end else begin
        rev_ones_s = rev_ones_r - 4'd1;
      end
    end else begin
      err_s = err;
    end
  end

  // Register the revolution count, the sticky error flag and the one-cycle wrap pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rev_ones_r <= 4'd0;
      rev_tens_r <= 4'd0;
      err        <= 1'b0;
      wrap_up    <= 1'b0;
      wrap_dn    <= 1'b0;
    end else begin
      rev_ones_r <= rev_ones_s;
      rev_tens_r <= rev_tens_s;
      err        <= err_s;
      wrap_up    <= wrap_up_s;
      wrap_dn    <= wrap_dn_s;
    end
  end

  // Keep each digit enabled for SCAN_DIV cycles, then advance to the next digit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_r <= 16'd0;
      dig_r      <= 2'd0;
    end else if (scan_cnt_r == 16'(SCAN_DIV - 1)) begin
      scan_cnt_r <= 16'd0;
      dig_r      <= dig_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + 16'd1;
    end
  end

  // Select the content of the current digit and apply the segment polarity.
  always_comb begin
    seg_hi_s = 7'b0000000;
    case (dig_r)
      2'd0:    seg_hi_s = seg_hex7({1'b0, q_s_r});
      2'd1:    seg_hi_s = err ? SEG_E_HI : 7'b0000000;
      2'd2:    seg_hi_s = seg_hex7(rev_ones_r);
      2'd3:    seg_hi_s = seg_hex7(rev_tens_r);
      default: seg_hi_s = 7'b0000000;
    endcase
    seg_s = SEG_ACT_LOW ? ~seg_hi_s : seg_hi_s;
    an_s  = ~(4'b0001 << dig_r);
  end

  // Register the anode enables and the segments on the same edge, so digit
  // switches have no blanking interval.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg <= SEG_RST_VAL;
      an  <= 4'b1110;
    end else begin
      seg <= seg_s;
      an  <= an_s;
    end
  end

endmodule

// File: tb/tb_up_down_wrap_display.sv
// Testbench for up_down_wrap_display. A behavioural model computes every
// output on every cycle. Hand-computed literals pin the reset state, pulse
// counts, the scan pattern and revolution values.
module tb_up_down_wrap_display;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst, clr;
  logic [2:0] q;
  logic [6:0] seg;
  logic [3:0] an;
  logic       wrap_up, wrap_dn, err;

  int checks = 0;
  int failures = 0;
  int cnt_wu = 0;
  int cnt_wd = 0;

  // model state
  int         m_qs, m_qp, m_k, m_t, m_rev;
  bit         m_err, m_wu, m_wd;
  logic [6:0] m_seg;
  logic [3:0] m_an;
  logic [6:0] lut [10];

  up_down_wrap_display #(.SCAN_DIV(S), .SEG_ACT_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .q(q), .clr(clr),
    .seg(seg), .an(an), .wrap_up(wrap_up), .wrap_dn(wrap_dn), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] disp(input int dg);
    logic [6:0] p;
    case (dg)
      0:       p = lut[m_qs];
      1:       p = m_err ? 7'b1111001 : 7'b0000000;
      2:       p = lut[m_rev % 10];
      default: p = lut[m_rev / 10];
    endcase
    return ~p;
  endfunction

  task automatic model_step();
    int d;
    bit nwu, nwd;
    if (!rst) begin
      m_qs = 0; m_qp = 0; m_k = 0; m_t = 0; m_rev = 0;
      m_err = 1'b0; m_wu = 1'b0; m_wd = 1'b0;
      m_an = 4'b1110; m_seg = 7'b1000000;
    end else begin
      m_an  = ~(4'b0001 << ((m_t / S) % 4));
      m_seg = disp((m_t / S) % 4);
      d   = (m_qs - m_qp + 8) % 8;
      nwu = 1'b0;
      nwd = 1'b0;
      if (clr) begin
        m_rev = 0;
        m_err = 1'b0;
      end else if (m_k >= 2) begin
        if (d >= 2 && d <= 6) m_err = 1'b1;
        if (m_qp == 7 && m_qs == 0) begin nwu = 1'b1; m_rev = (m_rev + 1) % 100; end
        if (m_qp == 0 && m_qs == 7) begin nwd = 1'b1; m_rev = (m_rev + 99) % 100; end
      end
      m_wu = nwu;
      m_wd = nwd;
      m_qp = m_qs;
      m_qs = int'(q);
      if (m_k < 2) m_k++;
      m_t++;
    end
  endtask

  task automatic cycle(input int qv, input bit cl, input bit r);
    q   = 3'(qv);
    clr = cl;
    rst = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("seg", int'(seg), int'(m_seg));
    chk("an", int'(an), int'(m_an));
    chk("wrap_up", int'(wrap_up), int'(m_wu));
    chk("wrap_dn", int'(wrap_dn), int'(m_wd));
    chk("err", int'(err), int'(m_err));
    if (wrap_up) cnt_wu++;
    if (wrap_dn) cnt_wd++;
  endtask

  initial begin
    logic [3:0] exp_an [4];
    logic [6:0] exp_sg [4];
    bit found;
    int wu_before;
    lut[0] = 7'h3F; lut[1] = 7'h06; lut[2] = 7'h5B; lut[3] = 7'h4F; lut[4] = 7'h66;
    lut[5] = 7'h6D; lut[6] = 7'h7D; lut[7] = 7'h07; lut[8] = 7'h7F; lut[9] = 7'h6F;
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;
    exp_sg[0] = 7'b0010010; exp_sg[1] = 7'b1111111; exp_sg[2] = 7'b1111000; exp_sg[3] = 7'b0110000;
    q = 3'd0; clr = 1'b0; rst = 1'b0;

    // reset state
    cycle(0, 1'b0, 1'b0);
    cycle(0, 1'b0, 1'b0);
    chk("rst_an", int'(an), 4'b1110);
    chk("rst_seg", int'(seg), 7'b1000000);
    chk("rst_pulses", int'({wrap_up, wrap_dn, err}), 0);

    // up stream: 37 revolutions, passing 09 -> 10
    for (int i = 1; i <= 296; i++) cycle(i % 8, 1'b0, 1'b1);
    for (int i = 1; i <= 5; i++) cycle(i, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(5, 1'b0, 1'b1);
    chk("wrap_up_cnt37", cnt_wu, 37);
    chk("model_rev37", m_rev, 37);
    chk("no_err_up", int'(err), 0);

    // scan pattern with rev=37, q=5
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (an == 4'b0111) found = 1'b1; else cycle(5, 1'b0, 1'b1);
    end
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (an == 4'b1110) found = 1'b1; else cycle(5, 1'b0, 1'b1);
    end
    chk("scan_sync", int'(found), 1);
    for (int j = 0; j < 16; j++) begin
      chk("scan_an", int'(an), int'(exp_an[j / 4]));
      chk("scan_seg", int'(seg), int'(exp_sg[j / 4]));
      cycle(5, 1'b0, 1'b1);
    end

    // 63 more up revolutions: 37 -> 99 -> 00
    for (int i = 6; i < 6 + 63 * 8; i++) cycle(i % 8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(5, 1'b0, 1'b1);
    chk("wrap_up_cnt100", cnt_wu, 100);
    chk("model_rev00", m_rev, 0);

    // down stream: 00 -> 99 -> 98
    for (int i = 0; i < 14; i++) cycle(((4 - i) % 8 + 8) % 8, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(7, 1'b0, 1'b1);
    chk("wrap_dn_cnt", cnt_wd, 2);
    chk("model_rev98", m_rev, 98);

    // illegal jump 2 -> 5
    for (int v = 6; v >= 2; v--) cycle(v, 1'b0, 1'b1);
    cycle(2, 1'b0, 1'b1);
    cycle(5, 1'b0, 1'b1);
    chk("err_not_yet", int'(err), 0);
    cycle(5, 1'b0, 1'b1);
    chk("err_set", int'(err), 1);
    for (int i = 0; i < 2 * S + 2; i++) cycle(5, 1'b0, 1'b1);
    chk("err_sticky", int'(err), 1);
    chk("model_rev98_jump", m_rev, 98);

    // clr coincides with a 7 -> 0 step
    cycle(6, 1'b0, 1'b1);
    cycle(7, 1'b0, 1'b1);
    wu_before = cnt_wu;
    cycle(0, 1'b0, 1'b1);
    cycle(0, 1'b1, 1'b1);
    chk("clr_no_wrap", int'(wrap_up), 0);
    chk("clr_err", int'(err), 0);
    chk("model_rev_clr", m_rev, 0);
    cycle(0, 1'b0, 1'b1);
    chk("clr_wu_cnt", cnt_wu, wu_before);

    // reset mid-count
    for (int v = 1; v <= 6; v++) cycle(v, 1'b0, 1'b1);
    cycle(7, 1'b0, 1'b0);
    chk("mid_rst_an", int'(an), 4'b1110);
    chk("mid_rst_seg", int'(seg), 7'b1000000);
    chk("mid_rst_flags", int'({wrap_up, wrap_dn, err}), 0);
    wu_before = cnt_wu;
    for (int v = 0; v < 6; v++) cycle(v, 1'b0, 1'b1);
    chk("post_rst_no_wrap", cnt_wu, wu_before);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/up_down_wrap_display.md
# up_down_wrap_display

Downstream consumer of the 3-bit up/down counter output `q`. It registers the incoming count and classifies each change as an up step, down step, hold or illegal jump. It keeps a two-digit BCD count of full revolutions (7→0 up, 0→7 down) and drives a 4-digit time-multiplexed seven-segment display showing the live count, an error marker and the revolution count.

## Interface
- `SCAN_DIV`, 16: clock cycles each digit is enabled; legal range 2..65535.
- `SEG_ACT_LOW`, 1: 1 = `seg` is active-low, 0 = active-high; `an` is always active-low.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `q` in 3: count from the up/down counter; may change combinationally between edges.
- `clr` in 1: synchronous active-high clear of revolution count and error flag.
- `seg` out 7: segments {g,f,e,d,c,b,a}, registered.
- `an` out 4: digit enables, one-hot active-low, registered.
- `wrap_up` out 1: one-cycle pulse, up revolution detected.
- `wrap_dn` out 1: one-cycle pulse, down revolution detected.
- `err` out 1: sticky flag, non-adjacent jump detected.

## Operation
- Capture stage: `q_s <= q` every edge. `q_p <= q_s` every edge. `p_vld` is set one edge after reset release.
- Classification while `p_vld=1`, with d = (q_s − q_p) mod 8, 3-bit wrap arithmetic:
  - d=1: up step.
  - d=7: down step.
  - d=0: hold, no action.
  - d=2..6: jump. Set `err` and leave the revolution count unchanged.
- No classification while `p_vld=0`.
- Up revolution is `q_p`=7 and `q_s`=0. Down revolution is `q_p`=0 and `q_s`=7. All other steps do not touch the revolution count.
- Revolution count `rev` is two BCD digits (tens, ones), range 00..99:
  - Up revolution increments it; 99 → 00.
  - Down revolution decrements it; 00 → 99.
  - Ones digit carries and borrows into tens.
- `clr=1` has priority over any revolution or jump in the same cycle: `rev` ← 00, `err` ← 0, and `wrap_up`/`wrap_dn` are not asserted that cycle.
- Display scan:
  - `scan_cnt` counts 0..SCAN_DIV−1.
  - At terminal count, `dig` advances 0→1→2→3→0.
  - `an` has bit `dig` low and all others high.
- Digit content:
  - dig0: `q_s` value 0..7.
  - dig1: letter E (segments a,d,e,f,g) when `err`=1, otherwise blank (all segments off).
  - dig2: `rev` ones digit.
  - dig3: `rev` tens digit.
- Segment code for digits 0..9 is the standard hex7 pattern. `SEG_ACT_LOW` inverts the whole vector.
- FSM-free datapath apart from the 4-state `dig` scanner. Illegal `dig` values are unreachable (2-bit wrap).

## Timing
- Reset (`rst`=0 at an edge), all values take effect at that edge:
  - `q_s`, `q_p`, `rev`, `scan_cnt` ← 0.
  - `dig` ← 0, `p_vld` ← 0, `err` ← 0, `wrap_up` = `wrap_dn` ← 0.
  - `an` ← 4'b1110.
  - `seg` ← code for '0': 7'b1000000 when `SEG_ACT_LOW`=1, 7'b0111111 when 0.
- Reset mid-operation discards all history. No classification happens until two edges after reset release.
- Latency:
  - `q` sampled at edge N appears in `q_s` after N.
  - It is compared with `q_p` during cycle N→N+1.
  - `wrap_up`/`wrap_dn`/`err` and the updated `rev` are registered at edge N+1.
  - Pulses are high for exactly one cycle, N+1→N+2.
- `seg`/`an` are registered from `dig` and the current digit value. A new `rev` or `q_s` value is visible the next edge its digit is selected.
- Digit switch: `an` and `seg` change on the same edge. There is no blanking interval.
- Full scan period is 4·SCAN_DIV cycles.

## Test plan
- Reset then u_d=1 stream (q = 1,2,…,7,0,1…): `err`=0 throughout; `wrap_up` pulses once per 8 cycles, 1 cycle after q_s=0; `rev` reads 01, 02, …
- Down stream (q = 7,6,…,0,7): from `rev`=00, first down wrap gives `rev`=99 and one `wrap_dn` pulse; the next down wrap gives 98.
- Up wraps from `rev`=09: next gives 10, tens digit updates. From 99, next up wrap gives 00.
- Drive q 2 → 5: `err`=1 two edges later and stays set; dig1 shows E; `rev` unchanged. Then assert `clr`=1 in the same cycle as a 7→0 step: `rev`=00, `err`=0, no `wrap_up` pulse.
- SCAN_DIV=4, rev=37, q=5: `an` sequence 1110,1101,1011,0111, each for 4 cycles; `seg` (active-low) shows 5, blank (1111111), 7, 3.
- Drop `rst` for one edge mid-count with q=6: all outputs at their reset values; the q=7 → 0 transition seen on the first edge after release does not produce `wrap_up`.
